// File: rtl/ioctl_sdram_loader.sv
// Packs the HPS ROM download byte stream into 32-bit little-endian words and writes them to SDRAM.
// Latency: a completed word raises sdram_req one clock after its last byte is captured.
// Backpressure: ioctl_wait is high while a word is pending, the assembly word is full, or a flush is due.
module ioctl_sdram_loader #(
    parameter int                  IOCTL_AW  = 20,
    parameter int                  SDRAM_AW  = 23,
    parameter logic [SDRAM_AW-1:0] BASE_ADDR = '0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [IOCTL_AW-1:0] ioctl_addr,
    input  logic [7:0]          ioctl_data,
    input  logic                ioctl_wr,
    input  logic                ioctl_download,
    output logic                ioctl_wait,
    output logic [SDRAM_AW-1:0] sdram_addr,
    output logic [31:0]         sdram_data,
    output logic                sdram_we,
    output logic                sdram_req,
    input  logic                sdram_ack,
    output logic                done,
    output logic                overflow
);
    // Word address of a 32-bit word in the byte stream, and the width used to
    // widen {word_addr,0} before truncating it into the SDRAM address space.
    localparam int WAW   = IOCTL_AW - 2;
    localparam int EXT_W = (IOCTL_AW - 1 > SDRAM_AW) ? IOCTL_AW - 1 : SDRAM_AW;

    typedef enum logic {
        S_IDLE,
        S_REQ
    } state_t;

    state_t              state_q, state_d;

    // Assembly register: bytes collect here until the word is complete.
    logic [31:0]         asm_dat_q, asm_dat_d;
    logic [WAW-1:0]      asm_addr_q, asm_addr_d;
    logic [3:0]          asm_mask_q, asm_mask_d;

    // Pending register: one word waiting for (or being offered to) SDRAM.
    logic [31:0]         pend_dat_q, pend_dat_d;
    logic [SDRAM_AW-1:0] pend_addr_q, pend_addr_d;
    logic                pend_vld_q, pend_vld_d;

    logic                dl_q;
    logic                active_q, active_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;

    logic                req_w;
    logic                asm_full;
    logic                asm_nonempty;
    logic                flush_pend;
    logic                wait_w;
    logic                byte_acc;
    logic                addr_break;
    logic                move_asm;
    logic                ack_take;
    logic [WAW-1:0]      byte_waddr;
    logic [1:0]          byte_lane;
    logic [3:0]          lane_bit;
    logic [EXT_W-1:0]    asm_word_ext;
    logic [SDRAM_AW-1:0] asm_sdram_addr;

    assign byte_waddr   = ioctl_addr[IOCTL_AW-1:2];
    assign byte_lane    = ioctl_addr[1:0];
    assign lane_bit     = 4'b0001 << byte_lane;

    assign asm_full     = &asm_mask_q;
    assign asm_nonempty = |asm_mask_q;
    // Download has ended (seen through the registered copy) with a partial word left behind.
    assign flush_pend   = ~dl_q & asm_nonempty;
    assign wait_w       = pend_vld_q | asm_full | flush_pend;

    assign byte_acc     = ioctl_wr & ~wait_w;
    // A byte for a different word while one is half built: retire the old word first.
    // wait_w being low guarantees PEND is free to take it.
    assign addr_break   = byte_acc & asm_nonempty & (byte_waddr != asm_addr_q);
    // ASM only moves into an empty PEND; an ack on the same edge frees PEND for the next edge.
    assign move_asm     = ~pend_vld_q & (asm_full | flush_pend | addr_break);
    assign ack_take     = (state_q == S_REQ) & sdram_ack;

    // SDRAM takes 16-bit word addresses; wrap is modulo 2^SDRAM_AW.
    assign asm_word_ext   = EXT_W'({asm_addr_q, 1'b0});
    assign asm_sdram_addr = asm_word_ext[SDRAM_AW-1:0] + BASE_ADDR;

    // Next-state for the assembly / pending registers and the status flags.
    always_comb begin
        asm_dat_d   = asm_dat_q;
        asm_addr_d  = asm_addr_q;
        asm_mask_d  = asm_mask_q;
        pend_dat_d  = pend_dat_q;
        pend_addr_d = pend_addr_q;
        pend_vld_d  = pend_vld_q;
        ovf_d       = ovf_q | (ioctl_wr & wait_w);

        if (ack_take) begin
            pend_vld_d = 1'b0;
        end

        // Unwritten lanes stay zero because ASM data is cleared whenever a word leaves.
        if (move_asm) begin
            pend_dat_d  = asm_dat_q;
            pend_addr_d = asm_sdram_addr;
            pend_vld_d  = 1'b1;
            asm_dat_d   = '0;
            asm_mask_d  = '0;
        end

        if (byte_acc) begin
            if (addr_break || !asm_nonempty) begin
                asm_dat_d                            = '0;
                asm_dat_d[{byte_lane, 3'b000} +: 8] = ioctl_data;
                asm_addr_d                           = byte_waddr;
                asm_mask_d                           = lane_bit;
            end else begin
                asm_dat_d[{byte_lane, 3'b000} +: 8] = ioctl_data;
                asm_mask_d                           = asm_mask_q | lane_bit;
            end
        end

        // Completion needs a download seen since the last pulse, and nothing left to write.
        done_d   = ~ioctl_download & ~asm_nonempty & ~pend_vld_q & active_q;
        active_d = done_d ? 1'b0 : (active_q | ioctl_download);
    end

    // SDRAM request FSM: next state and request outputs.
    always_comb begin
        state_d = state_q;
        req_w   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (move_asm) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                req_w = 1'b1;
                if (sdram_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and status registers; reset discards any in-flight word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            asm_dat_q   <= '0;
            asm_addr_q  <= '0;
            asm_mask_q  <= '0;
            pend_dat_q  <= '0;
            pend_addr_q <= '0;
            pend_vld_q  <= 1'b0;
            dl_q        <= 1'b0;
            active_q    <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            asm_dat_q   <= asm_dat_d;
            asm_addr_q  <= asm_addr_d;
            asm_mask_q  <= asm_mask_d;
            pend_dat_q  <= pend_dat_d;
            pend_addr_q <= pend_addr_d;
            pend_vld_q  <= pend_vld_d;
            dl_q        <= ioctl_download;
            active_q    <= active_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
        end
    end

    assign ioctl_wait = wait_w;
    assign sdram_addr = pend_addr_q;
    assign sdram_data = pend_dat_q;
    assign sdram_req  = req_w;
    assign sdram_we   = req_w;
    assign done       = done_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_ioctl_sdram_loader.sv
// Self-checking bench: byte stream stimulus, word-grouping reference model, write scoreboard.
// Expected SDRAM writes are queued by the model; a monitor pops them at each req/ack handshake.
// Ack timing is varied (tied, fixed delay, random with spurious idle acks, held off).
module tb_ioctl_sdram_loader;
    localparam int          IOCTL_AW = 20;
    localparam int          SDRAM_AW = 23;
    localparam logic [22:0] BASE     = 23'h000000;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [IOCTL_AW-1:0] ioctl_addr = '0;
    logic [7:0]          ioctl_data = '0;
    logic                ioctl_wr = 1'b0;
    logic                ioctl_download = 1'b0;
    logic                ioctl_wait;
    logic [SDRAM_AW-1:0] sdram_addr;
    logic [31:0]         sdram_data;
    logic                sdram_we;
    logic                sdram_req;
    logic                sdram_ack = 1'b0;
    logic                done;
    logic                overflow;

    always #5 clk = ~clk;

    ioctl_sdram_loader #(
        .IOCTL_AW (IOCTL_AW),
        .SDRAM_AW (SDRAM_AW),
        .BASE_ADDR(BASE)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ioctl_addr    (ioctl_addr),
        .ioctl_data    (ioctl_data),
        .ioctl_wr      (ioctl_wr),
        .ioctl_download(ioctl_download),
        .ioctl_wait    (ioctl_wait),
        .sdram_addr    (sdram_addr),
        .sdram_data    (sdram_data),
        .sdram_we      (sdram_we),
        .sdram_req     (sdram_req),
        .sdram_ack     (sdram_ack),
        .done          (done),
        .overflow      (overflow)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_writes = 0;
    int done_cnt = 0;

    typedef struct {
        logic [22:0] addr;
        logic [31:0] dat;
    } wr_t;
    wr_t exp_q[$];
    wr_t mon_w;

    // Reference model: the current word being collected from the byte stream.
    logic [17:0] m_waddr = '0;
    logic [7:0]  m_lane[4];
    logic [3:0]  m_have = '0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    function automatic void fail_now(input string name);
        n_checks++;
        $display("FAIL %s: bounded wait expired", name);
    endfunction

    // Emit the collected word: byte k at bits [8k+7:8k], absent bytes zero,
    // SDRAM address is twice the 32-bit word index plus the base, mod 2^23.
    function automatic void m_emit();
        wr_t w;
        logic [22:0] wa;
        wa = {5'b0, m_waddr};
        w.addr = BASE + wa * 23'd2;
        for (int k = 0; k < 4; k++)
            w.dat[8*k +: 8] = m_have[k] ? m_lane[k] : 8'h00;
        exp_q.push_back(w);
        m_have = '0;
    endfunction

    function automatic void model_byte(input logic [19:0] a, input logic [7:0] d);
        if (m_have != 0 && a[19:2] != m_waddr) m_emit();
        if (m_have == 0) m_waddr = a[19:2];
        m_lane[a[1:0]] = d;
        m_have[a[1:0]] = 1'b1;
        if (m_have == 4'hF) m_emit();
    endfunction

    function automatic void model_flush();
        if (m_have != 0) m_emit();
    endfunction

    // Ack driver, updated just after each rising edge. Modes: 0 tied high, 1 fixed delay,
    // 2 random delay plus stray acks while idle, 3 never ack.
    int ack_mode  = 1;
    int ack_delay = 0;
    int ack_cnt   = 0;
    always @(posedge clk) begin
        #1;
        if (!reset_n) begin
            sdram_ack = 1'b0;
            ack_cnt   = 0;
        end else if (ack_mode == 0) begin
            sdram_ack = 1'b1;
        end else if (ack_mode == 3) begin
            sdram_ack = 1'b0;
        end else if (sdram_ack) begin
            sdram_ack = 1'b0;
        end else if (sdram_req) begin
            if (ack_cnt >= ack_delay) begin
                sdram_ack = 1'b1;
                ack_cnt   = 0;
                if (ack_mode == 2) ack_delay = $urandom_range(0, 4);
            end else begin
                ack_cnt++;
            end
        end else if (ack_mode == 2 && $urandom_range(0, 5) == 0) begin
            sdram_ack = 1'b1;
        end
    end

    // Scoreboard monitor: a handshake is req and ack both high going into the next rising edge.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && sdram_req === 1'b1 && sdram_ack === 1'b1) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", sdram_addr, sdram_data);
            end else begin
                mon_w = exp_q.pop_front();
                check("wr_addr", 64'(sdram_addr), 64'(mon_w.addr));
                check("wr_data", 64'(sdram_data), 64'(mon_w.dat));
                check("wr_we", 64'(sdram_we), 64'd1);
            end
        end
        if (done === 1'b1) done_cnt++;
    end

    // Callers are positioned at a falling edge. Unless forced, wait for ioctl_wait to drop.
    task automatic send_byte(input logic [19:0] a, input logic [7:0] d, input bit force_wr);
        int g = 0;
        while (!force_wr && ioctl_wait && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!force_wr && ioctl_wait) fail_now("byte_wait");
        if (!ioctl_wait) model_byte(a, d);
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        @(negedge clk);
        ioctl_wr   = 1'b0;
    endtask

    task automatic wait_req(input string name);
        int g = 0;
        while (!sdram_req && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!sdram_req) fail_now(name);
    endtask

    task automatic end_download();
        int g = 0;
        int d0;
        d0 = done_cnt;
        ioctl_download = 1'b0;
        model_flush();
        while (done_cnt == d0 && g < 300) begin
            @(negedge clk);
            g++;
        end
        check("done_seen", 64'(done_cnt - d0), 64'd1);
        check("sb_drained", 64'(exp_q.size()), 64'd0);
        repeat (4) @(negedge clk);
        check("done_single", 64'(done_cnt - d0), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int held;
        int g;
        int w0;
        int d0;
        bit wait_ok;
        logic [19:0] a;

        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        check("rst_req", 64'(sdram_req), 64'd0);
        check("rst_we", 64'(sdram_we), 64'd0);
        check("rst_wait", 64'(ioctl_wait), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_addr", 64'(sdram_addr), 64'd0);
        check("rst_data", 64'(sdram_data), 64'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Single word, ack three cycles after request.
        ack_mode = 1;
        ack_delay = 2;
        ioctl_download = 1'b1;
        @(negedge clk);
        send_byte(20'h0, 8'h11, 1'b0);
        send_byte(20'h1, 8'h22, 1'b0);
        send_byte(20'h2, 8'h33, 1'b0);
        send_byte(20'h3, 8'h44, 1'b0);
        check("t1_req_at_E", 64'(sdram_req), 64'd0);
        check("t1_wait_at_E", 64'(ioctl_wait), 64'd1);
        @(negedge clk);
        check("t1_req_at_E1", 64'(sdram_req), 64'd1);
        held = 0;
        g = 0;
        wait_ok = 1'b1;
        while (sdram_req && g < 50) begin
            held++;
            if (!ioctl_wait) wait_ok = 1'b0;
            @(negedge clk);
            g++;
        end
        check("t1_req_held", 64'(held), 64'd3);
        check("t1_wait_during_req", 64'(wait_ok), 64'd1);
        check("t1_wait_after_ack", 64'(ioctl_wait), 64'd0);
        end_download();

        // Eight sequential bytes from byte address 8, ack tied high.
        ack_mode = 0;
        ioctl_download = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) send_byte(20'(8 + i), 8'($urandom), 1'b0);
        end_download();
        ack_mode = 1;
        ack_delay = 1;
        @(negedge clk);

        // Partial word flushed when the download ends.
        ioctl_download = 1'b1;
        @(negedge clk);
        send_byte(20'h10, 8'hAA, 1'b0);
        send_byte(20'h11, 8'hBB, 1'b0);
        send_byte(20'h12, 8'hCC, 1'b0);
        end_download();

        // Address discontinuity retires a one-byte word.
        ack_mode = 2;
        ioctl_download = 1'b1;
        @(negedge clk);
        send_byte(20'h000, 8'h5A, 1'b0);
        send_byte(20'h100, 8'hA5, 1'b0);
        end_download();

        // Bytes pushed while stalled are dropped and latch overflow.
        ack_mode = 3;
        ioctl_download = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) send_byte(20'(8'h40 + i), 8'(8'h20 + i), 1'b0);
        wait_req("t5_req");
        w0 = n_writes;
        for (int i = 0; i < 4; i++) send_byte(20'(8'h44 + i), 8'(8'h90 + i), 1'b1);
        check("t5_overflow", 64'(overflow), 64'd1);
        check("t5_wait_held", 64'(ioctl_wait), 64'd1);
        ack_delay = 0;
        ack_mode = 1;
        repeat (8) @(negedge clk);
        check("t5_one_write", 64'(n_writes - w0), 64'd1);
        end_download();
        check("t5_overflow_sticky", 64'(overflow), 64'd1);

        // Reset while a request is outstanding.
        ack_mode = 3;
        ioctl_download = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) send_byte(20'(8'h80 + i), 8'($urandom), 1'b0);
        wait_req("t6_req");
        w0 = n_writes;
        d0 = done_cnt;
        #2 reset_n = 1'b0;
        #1;
        check("t6_req", 64'(sdram_req), 64'd0);
        check("t6_we", 64'(sdram_we), 64'd0);
        check("t6_done", 64'(done), 64'd0);
        check("t6_wait", 64'(ioctl_wait), 64'd0);
        check("t6_ovf", 64'(overflow), 64'd0);
        exp_q.delete();
        m_have = '0;
        ioctl_download = 1'b0;
        ack_mode = 1;
        ack_delay = 0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("t6_no_write", 64'(n_writes - w0), 64'd0);
        check("t6_no_done", 64'(done_cnt - d0), 64'd0);

        // Randomized sessions: runs of sequential bytes at random addresses, random ack timing.
        ack_mode = 2;
        for (int s = 0; s < 8; s++) begin
            ioctl_download = 1'b1;
            @(negedge clk);
            for (int r = 0; r < int'($urandom_range(1, 5)); r++) begin
                if ($urandom_range(0, 1) == 0) a = 20'($urandom_range(0, 63));
                else a = 20'($urandom);
                for (int i = 0; i < int'($urandom_range(1, 10)); i++) begin
                    send_byte(20'(a + 20'(i)), 8'($urandom), 1'b0);
                    if ($urandom_range(0, 3) == 0) @(negedge clk);
                end
            end
            end_download();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
